// File: rtl/cpu_pipe_ctrl.sv
// rtl/cpu_pipe_ctrl.sv - pipeline stall/flush controller with MDU sequencing and stall counter
//
// Purpose: resolves load-use, multi-cycle MDU, data-cache miss and exception
// hazards into per-stage hold/bubble/flush controls for a five-stage pipeline.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_raddr1/2, id_re1/2           source registers used by the ID instruction
//   ex_is_load, ex_we, ex_waddr     destination info of the EX instruction
//   ex_mdu_start, ex_mdu_div        MDU issue pulse and divide/multiply select
//   mem_stall_req                   data cache not ready (level)
//   exc_req                         exception commit pulse from MEM
//   stall_pc/if_id/id_ex/ex_mem     hold the PC or the named stage register
//   bubble_id_ex, bubble_mem_wb     insert a NOP into the named register
//   flush_all, redirect_pc          exception flush and vector redirect
//   mdu_busy, mdu_done, mdu_abort   MDU sequencing status and kill
//   stall_cnt                       count of cycles with stall_pc asserted
module cpu_pipe_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic        ex_is_load,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_div,
  input  logic        mem_stall_req,
  input  logic        exc_req,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        bubble_id_ex,
  output logic        bubble_mem_wb,
  output logic        flush_all,
  output logic        redirect_pc,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic        mdu_abort,
  output logic [31:0] stall_cnt
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_MDU, S_FLUSH} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_mdu_cnt;
  logic [31:0]      r_stall_cnt;

  logic w_run;
  logic w_mdu;
  logic w_flush;
  logic w_lu;
  logic w_mdu_stall;

  assign w_run   = (r_state == S_RUN);
  assign w_mdu   = (r_state == S_MDU);
  assign w_flush = (r_state == S_FLUSH);

  assign w_lu = ex_is_load & ex_we & (ex_waddr != 5'd0) &
                ((id_re1 & (ex_waddr == id_raddr1)) | (id_re2 & (ex_waddr == id_raddr2)));

  // The issuing cycle stalls too, so a start holds the pipe for the full N cycles.
  assign w_mdu_stall = (w_run & ex_mdu_start) | (w_mdu & (r_mdu_cnt != '0));

  // Status outputs come only from state; reset drives state to RUN so they drop at once.
  assign mdu_busy  = w_mdu;
  assign mdu_done  = w_mdu & (r_mdu_cnt == '0);
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    stall_ex_mem  = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_mem_wb = 1'b0;
    flush_all     = 1'b0;
    redirect_pc   = 1'b0;
    mdu_abort     = 1'b0;
    // Inputs may be live during reset; gate so every control is quiet while rst_n is low.
    if (rst_n) begin
      if (exc_req) begin
        flush_all   = 1'b1;
        redirect_pc = 1'b1;
        mdu_abort   = w_mdu | (w_run & ex_mdu_start);
      end else if (!w_flush) begin
        if (mem_stall_req || w_mdu_stall) begin
          stall_pc      = 1'b1;
          stall_if_id   = 1'b1;
          stall_id_ex   = 1'b1;
          stall_ex_mem  = 1'b1;
          bubble_mem_wb = 1'b1;
        end else if (w_run && w_lu) begin
          // Hold IF/ID and PC, let EX drain with a bubble behind the load.
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_mdu_cnt   <= '0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, stall_pc};
      if (exc_req) begin
        r_state   <= S_FLUSH;
        r_mdu_cnt <= '0;
      end else begin
        case (r_state)
          S_RUN: begin
            // Accepted even under a cache miss: the MDU runs independently of the hold.
            if (ex_mdu_start) begin
              r_mdu_cnt <= ex_mdu_div ? DIV_LOAD : MULT_LOAD;
              r_state   <= S_MDU;
            end
          end
          S_MDU: begin
            if (r_mdu_cnt == '0) begin
              r_state <= S_RUN;
            end else begin
              r_mdu_cnt <= r_mdu_cnt - 1'b1;
            end
          end
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
# cpu_pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It takes hazard information from the ID, EX and MEM stages and produces per-stage freeze and bubble controls. It detects load-use hazards that ID-stage forwarding cannot resolve, sequences multi-cycle multiply/divide operations in EX, handles data-cache miss stalls, and handles exception flushes. It also keeps a free-running count of stall cycles for performance monitoring.

## Interface
Parameters:
- MULT_CYCLES, 4, EX occupancy of a multiply; must be ≥ 2
- DIV_CYCLES, 32, EX occupancy of a divide; must be ≥ 2

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_raddr1  in  5  rs address read by the instruction in ID
- id_raddr2  in  5  rt address read by the instruction in ID
- id_re1  in  1  ID instruction actually uses rs
- id_re2  in  1  ID instruction actually uses rt
- ex_is_load  in  1  instruction in EX is a load
- ex_we  in  1  instruction in EX writes a GPR
- ex_waddr  in  5  destination of the instruction in EX
- ex_mdu_start  in  1  EX issues a multi-cycle op (single-cycle pulse)
- ex_mdu_div  in  1  qualifies ex_mdu_start: 1 = divide, 0 = multiply
- mem_stall_req  in  1  data cache not ready; level signal
- exc_req  in  1  MEM stage commits an exception (single-cycle pulse)
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the PC or the named stage register
- bubble_id_ex, bubble_mem_wb  out  1 each  load a NOP into the named register
- flush_all  out  1  clear IF/ID, ID/EX, EX/MEM, MEM/WB
- redirect_pc  out  1  load the exception vector into the PC
- mdu_busy  out  1  an MDU operation is in progress
- mdu_done  out  1  MDU result valid; EX latches it this cycle
- mdu_abort  out  1  kill the in-flight MDU operation
- stall_cnt  out  32  number of cycles in which stall_pc was 1

## Operation
- FSM states: RUN, MDU, FLUSH. Reset state is RUN, with mdu_cnt=0 and stall_cnt=0.
- A load-use hazard (lu) is true when all of the following hold: ex_is_load, ex_we, ex_waddr≠0, and either (id_re1 and ex_waddr==id_raddr1) or (id_re2 and ex_waddr==id_raddr2).
- Control is resolved combinationally each cycle. Priorities are listed highest first:
  1. Exception (exc_req=1): flush_all=1 and redirect_pc=1, with all stall_* and bubble_* at 0. If the FSM is in MDU, or ex_mdu_start is high in RUN, mdu_abort=1. Next state is FLUSH and mdu_cnt clears to 0.
  2. Memory stall (mem_stall_req=1): stall_pc, stall_if_id, stall_id_ex and stall_ex_mem are all 1, and bubble_mem_wb=1.
  3. MDU busy (mdu_stall): this is true in RUN when ex_mdu_start=1, and true in MDU while mdu_cnt≠0. It drives stall_pc, stall_if_id, stall_id_ex and stall_ex_mem to 1, and bubble_mem_wb to 1.
  4. Load-use (lu, evaluated only in RUN): stall_pc=1, stall_if_id=1, bubble_id_ex=1.
  5. Otherwise all controls are 0.
- RUN, on ex_mdu_start with no exc_req: mdu_cnt is loaded with (ex_mdu_div ? DIV_CYCLES : MULT_CYCLES) − 1, and the next state is MDU. This happens even if mem_stall_req=1.
- MDU state:
  - mdu_busy=1.
  - mdu_cnt decrements every cycle regardless of mem_stall_req.
  - When mdu_cnt==0: mdu_done=1, mdu_stall=0, and the next state is RUN.
  - ex_mdu_start is ignored.
- FLUSH lasts exactly one cycle. All outputs are 0; ex_mdu_start and lu are ignored. Next state is RUN, unless exc_req arrives again, in which case the FSM stays in FLUSH.
- stall_cnt increments by 1 on every clock edge where stall_pc=1, and wraps from 0xFFFFFFFF to 0.

## Timing
- All stall, bubble and flush outputs are combinational from the inputs and the current state, with zero-cycle latency.
- mdu_busy and mdu_done are functions of registered state only.
- A start at cycle T stalls cycles T through T+N−1, where N is the configured cycle count. mdu_done is asserted in cycle T+N, and that cycle is unstalled unless another stall source is active.
- Exception at cycle T: flush_all is asserted in T and the FSM is in FLUSH during T+1. The earliest a new MDU start can be accepted is T+2.
- Reset may assert mid-operation. The FSM returns to RUN immediately, mdu_cnt and stall_cnt go to 0, and every output is 0 while rst_n=0.
- An lu and a mem stall occurring together produce the mem-stall pattern only. bubble_id_ex must not be asserted while stall_id_ex=1.

## Test plan
- **Load-use:** ex_is_load=1, ex_we=1, ex_waddr=5, id_re1=1, id_raddr1=5 → stall_pc=1, stall_if_id=1, bubble_id_ex=1 for one cycle. Repeat with ex_waddr=0 → no stall.
- **Divide:** ex_mdu_start=1, ex_mdu_div=1 at T → stall_ex_mem=1 for T..T+31, mdu_done=1 exactly at T+32, and stall_cnt has advanced by 32.
- **Multiply with cache miss:** a multiply starts at T and mem_stall_req is held high over T+2..T+6 → mdu_done still fires at T+4, stalls persist through T+6, and cycle T+7 is clear.
- **Exception aborts divide:** exc_req at T+10 of a divide → mdu_abort=1, flush_all=1 and redirect_pc=1 at T+10, mdu_busy=0 at T+11, and an ex_mdu_start at T+11 is ignored.
- **Async reset:** assert rst_n=0 mid-divide, between clock edges → all outputs go to 0 immediately. After release, the FSM is in RUN and stall_cnt=0.
- **stall_cnt wrap:** force stall_cnt to 0xFFFFFFFF, then apply one stall cycle → stall_cnt=0.
